// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg: shared constants and FSM state type for the score keeper.
`default_nettype none

package score_keeper_pkg;

   localparam int SK_SCORE_DIGITS = 5;
   localparam int SK_LIVES_INIT   = 3;
   localparam int SK_LIVES_MAX    = 9;

   typedef enum logic [1:0] {
      SK_IDLE  = 2'd0,
      SK_ADD   = 2'd1,
      SK_CHECK = 2'd2
   } sk_state_e;

endpackage

`default_nettype wire

// File: rtl/score_keeper_if.sv
// score_keeper_if: frame/event inputs and score/lives display outputs of the score keeper.
`default_nettype none

interface score_keeper_if
   import score_keeper_pkg::*;
#(
   parameter int NUM_SRC      = 2,
   parameter int SCORE_DIGITS = SK_SCORE_DIGITS
);
   logic                      vsync;
   logic                      game_begin;
   logic                      ship_hit;
   logic [NUM_SRC*11-1:0]     ast_points;
   logic [4*SCORE_DIGITS-1:0] score;
   logic [4*SCORE_DIGITS-1:0] high_score;
   logic [3:0]                lives;
   logic                      extra_life;
   logic                      game_over;
   logic                      busy;

   modport master (
      output vsync, game_begin, ship_hit, ast_points,
      input  score, high_score, lives, extra_life, game_over, busy
   );

   modport slave (
      input  vsync, game_begin, ship_hit, ast_points,
      output score, high_score, lives, extra_life, game_over, busy
   );
endinterface

`default_nettype wire

// File: rtl/score_keeper_bcd_adder.sv
// bcd_adder: combinational digit-ripple BCD adder with per-digit +6 correction.
`default_nettype none

module bcd_adder #(
   parameter int DIGITS = 5
) (
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   output logic [4*DIGITS-1:0] sum,
   output logic                carry_out
);

   logic [DIGITS:0] carry;

   assign carry[0] = 1'b0;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [4:0] raw;
      assign raw                = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + {4'b0, carry[g]};
      assign carry[g+1]         = (raw > 5'd9);
      // raw is at most 19; adding 6 modulo 16 yields the corrected digit
      assign sum[4*g +: 4]      = carry[g+1] ? (raw[3:0] + 4'd6) : raw[3:0];
   end

   assign carry_out = carry[DIGITS];

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// score_keeper: per-frame BCD score accumulation, lives, extra-life award and high score.
`default_nettype none

module score_keeper
   import score_keeper_pkg::*;
#(
   parameter int NUM_SRC      = 2,
   parameter int SCORE_DIGITS = SK_SCORE_DIGITS
) (
   input  wire logic     clk,
   input  wire logic     resetN,
   score_keeper_if.slave bus
);

   localparam int SW    = 4 * SCORE_DIGITS;
   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

   sk_state_e        state_q, state_d;
   logic [IDX_W-1:0] src_idx_q, src_idx_d;
   logic [10:0]      held_q [NUM_SRC];
   logic [3:0]       old_top_q;
   logic [SW-1:0]    score_q, score_d, high_q, high_d, sum;
   logic [3:0]       lives_q, lives_d;
   logic             extra_q, extra_d;
   logic             go_q, go_d, go_dly_q, vsync_q;
   logic             capture, award, hit, unused_carry;

   bcd_adder #(.DIGITS(SCORE_DIGITS)) u_add (
      .a         (score_q),
      .b         ({{(SW-11){1'b0}}, held_q[src_idx_q]}),
      .sum       (sum),
      .carry_out (unused_carry)
   );

   assign capture = vsync_q && !go_q && (state_q == SK_IDLE);

   always_comb begin
      state_d   = state_q;
      src_idx_d = src_idx_q;
      score_d   = score_q;
      lives_d   = lives_q;
      go_d      = go_q;
      high_d    = high_q;
      extra_d   = 1'b0;
      award     = 1'b0;

      case (state_q)
         SK_IDLE: begin
            if (capture) begin
               state_d   = SK_ADD;
               src_idx_d = '0;
            end
         end
         SK_ADD: begin
            score_d = sum;
            if (src_idx_q == LAST_IDX) state_d = SK_CHECK;
            else                       src_idx_d = IDX_W'(src_idx_q + 1);
         end
         SK_CHECK: begin
            award   = (score_q[SW-1 -: 4] != old_top_q);
            extra_d = award;
            state_d = SK_IDLE;
         end
         default: state_d = SK_IDLE;
      endcase

      // score is frozen once the game has ended
      if (go_q) begin
         state_d = SK_IDLE;
         score_d = score_q;
         award   = 1'b0;
         extra_d = 1'b0;
      end

      hit = bus.ship_hit && !go_q && (lives_q != 4'd0);
      if (award && !hit) begin
         if (lives_q != 4'(SK_LIVES_MAX)) lives_d = lives_q + 4'd1;
      end else if (hit && !award) begin
         lives_d = lives_q - 4'd1;
         if (lives_q == 4'd1) go_d = 1'b1;
      end

      if (go_q && !go_dly_q && (score_q > high_q)) high_d = score_q;

      if (bus.game_begin) begin
         state_d   = SK_IDLE;
         src_idx_d = '0;
         score_d   = '0;
         lives_d   = 4'(SK_LIVES_INIT);
         go_d      = 1'b0;
         extra_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= SK_IDLE;
         src_idx_q <= '0;
         old_top_q <= 4'd0;
         score_q   <= '0;
         high_q    <= '0;
         lives_q   <= 4'd0;
         extra_q   <= 1'b0;
         go_q      <= 1'b1;
         go_dly_q  <= 1'b1;
         vsync_q   <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) held_q[i] <= 11'd0;
      end else begin
         state_q   <= state_d;
         src_idx_q <= src_idx_d;
         score_q   <= score_d;
         high_q    <= high_d;
         lives_q   <= lives_d;
         extra_q   <= extra_d;
         go_q      <= go_d;
         go_dly_q  <= go_q;
         vsync_q   <= bus.vsync;
         if (capture) begin
            old_top_q <= score_q[SW-1 -: 4];
            for (int i = 0; i < NUM_SRC; i++) held_q[i] <= bus.ast_points[i*11 +: 11];
         end
      end
   end

   assign bus.score      = score_q;
   assign bus.high_score = high_q;
   assign bus.lives      = lives_q;
   assign bus.extra_life = extra_q;
   assign bus.game_over  = go_q;
   assign bus.busy       = (state_q != SK_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed self-checking bench for score_keeper.
`default_nettype none

module tb_score_keeper;
   import score_keeper_pkg::*;

   localparam int NS = 2;
   localparam int SD = 5;

   logic clk    = 1'b0;
   logic resetN = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [3:0]  f_busy;
   logic [19:0] f_s3;
   logic        f_el;

   always #5 clk = ~clk;

   score_keeper_if #(.NUM_SRC(NS), .SCORE_DIGITS(SD)) bus ();

   score_keeper #(.NUM_SRC(NS), .SCORE_DIGITS(SD)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic begin_game;
      bus.game_begin = 1'b1;
      tick;
      bus.game_begin = 1'b0;
   endtask

   task automatic hit;
      bus.ship_hit = 1'b1;
      tick;
      bus.ship_hit = 1'b0;
   endtask

   // One frame: vsync, then sample busy at +1..+4, score at +3, extra_life at +4.
   task automatic frame(input logic [10:0] p0, input logic [10:0] p1, input logic hit4);
      bus.vsync      = 1'b1;
      bus.ast_points = {p1, p0};
      tick;
      bus.vsync = 1'b0;
      tick; f_busy[0] = bus.busy;
      tick; f_busy[1] = bus.busy;
      tick; f_busy[2] = bus.busy; f_s3 = bus.score;
      bus.ship_hit = hit4;
      tick; f_busy[3] = bus.busy; f_el = bus.extra_life;
      bus.ship_hit = 1'b0;
      tick;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      bus.vsync      = 1'b0;
      bus.game_begin = 1'b0;
      bus.ship_hit   = 1'b0;
      bus.ast_points = '0;
      repeat (2) tick;
      check("rst_score", 32'(bus.score), 32'h0);
      check("rst_high",  32'(bus.high_score), 32'h0);
      check("rst_lives", 32'(bus.lives), 32'd0);
      check("rst_el",    32'(bus.extra_life), 32'd0);
      check("rst_go",    32'(bus.game_over), 32'd1);
      check("rst_busy",  32'(bus.busy), 32'd0);
      resetN = 1'b1;
      tick;

      frame(11'h020, 11'h100, 1'b0);
      check("pregame_score", 32'(bus.score), 32'h0);
      check("pregame_busy",  32'(f_busy), 32'h0);

      begin_game;
      check("begin_score", 32'(bus.score), 32'h0);
      check("begin_lives", 32'(bus.lives), 32'd3);
      check("begin_go",    32'(bus.game_over), 32'd0);
      check("begin_high",  32'(bus.high_score), 32'h0);

      frame(11'h020, 11'h100, 1'b0);
      check("f1_busy",  32'(f_busy), 32'b0111);
      check("f1_score", 32'(f_s3), 32'h00120);
      check("f1_el",    32'(f_el), 32'd0);
      check("f1_lives", 32'(bus.lives), 32'd3);

      repeat (12) frame(11'h400, 11'h400, 1'b0);
      frame(11'h200, 11'h060, 1'b0);
      check("pre10k_score", 32'(bus.score), 32'h09980);
      check("pre10k_lives", 32'(bus.lives), 32'd3);

      frame(11'h050, 11'h000, 1'b0);
      check("x10k_score", 32'(f_s3), 32'h10030);
      check("x10k_el",    32'(f_el), 32'd1);
      check("x10k_lives", 32'(bus.lives), 32'd4);
      check("x10k_el_end", 32'(bus.extra_life), 32'd0);

      repeat (12) frame(11'h400, 11'h400, 1'b0);
      frame(11'h300, 11'h030, 1'b0);
      check("pre20k_score", 32'(bus.score), 32'h19960);
      frame(11'h040, 11'h000, 1'b1);
      check("hitaward_score", 32'(f_s3), 32'h20000);
      check("hitaward_el",    32'(f_el), 32'd1);
      check("hitaward_lives", 32'(bus.lives), 32'd4);

      repeat (87) frame(11'h400, 11'h400, 1'b0);
      check("sat_run_score", 32'(bus.score), 32'h89600);
      check("sat_run_lives", 32'(bus.lives), 32'd9);
      frame(11'h300, 11'h060, 1'b0);
      frame(11'h040, 11'h000, 1'b0);
      check("sat_score", 32'(f_s3), 32'h90000);
      check("sat_el",    32'(f_el), 32'd1);
      check("sat_lives", 32'(bus.lives), 32'd9);

      repeat (12) frame(11'h400, 11'h400, 1'b0);
      frame(11'h300, 11'h060, 1'b0);
      check("prewrap_score", 32'(bus.score), 32'h99960);
      hit;
      check("hit_lives", 32'(bus.lives), 32'd8);
      frame(11'h100, 11'h000, 1'b0);
      check("wrap_score", 32'(f_s3), 32'h00060);
      check("wrap_el",    32'(f_el), 32'd1);
      check("wrap_lives", 32'(bus.lives), 32'd9);

      repeat (8) hit;
      check("last_life", 32'(bus.lives), 32'd1);
      check("last_go",   32'(bus.game_over), 32'd0);
      hit;
      check("over_lives", 32'(bus.lives), 32'd0);
      check("over_go",    32'(bus.game_over), 32'd1);
      tick;
      check("over_high",  32'(bus.high_score), 32'h00060);
      hit;
      check("over_hit_lives", 32'(bus.lives), 32'd0);
      frame(11'h400, 11'h400, 1'b0);
      check("over_frame_score", 32'(bus.score), 32'h00060);
      check("over_frame_busy",  32'(f_busy), 32'h0);

      begin_game;
      frame(11'h020, 11'h000, 1'b0);
      check("g2_score", 32'(bus.score), 32'h00020);
      repeat (3) hit;
      check("g2_go", 32'(bus.game_over), 32'd1);
      tick;
      check("g2_high",  32'(bus.high_score), 32'h00060);
      check("g2_score_hold", 32'(bus.score), 32'h00020);

      begin_game;
      bus.vsync      = 1'b1;
      bus.ast_points = {11'h100, 11'h100};
      tick;
      bus.vsync = 1'b0;
      tick;
      check("abort_busy", 32'(bus.busy), 32'd1);
      tick;
      check("abort_partial", 32'(bus.score), 32'h00100);
      bus.game_begin = 1'b1;
      tick;
      bus.game_begin = 1'b0;
      check("abort_score", 32'(bus.score), 32'h0);
      check("abort_idle",  32'(bus.busy), 32'd0);
      tick;
      check("abort_el",    32'(bus.extra_life), 32'd0);
      check("abort_score2", 32'(bus.score), 32'h0);

      bus.vsync      = 1'b1;
      bus.ast_points = {11'h100, 11'h100};
      tick;
      bus.vsync = 1'b0;
      repeat (2) tick;
      #2;
      resetN = 1'b0;
      #1;
      check("arst_score", 32'(bus.score), 32'h0);
      check("arst_busy",  32'(bus.busy), 32'd0);
      check("arst_go",    32'(bus.game_over), 32'd1);
      check("arst_lives", 32'(bus.lives), 32'd0);
      tick;
      resetN = 1'b1;
      tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
